// File: rtl/commu_m_arm_rd.sv
// rtl/commu_m_arm_rd.sv - ARM external-bus read engine for the master-side frame buffer
module commu_m_arm_rd #(
   parameter int AW        = 10,
   parameter int DW        = 16,
   parameter int FRM_WORDS = 512
) (
   input  logic          clk_sys,
   input  logic          rst,
   input  logic          arm_cs_n,
   input  logic          arm_oe_n,
   input  logic          arm_we_n,
   input  logic [1:0]    arm_addr,
   output logic [DW-1:0] arm_data,
   output logic          arm_data_oe,
   input  logic [7:0]    stu_buf_rdy,
   output logic [AW-1:0] buf_raddr,
   input  logic [DW-1:0] buf_rdata,
   output logic          buf_frm,
   output logic          buf_rd,
   output logic [7:0]    err_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READY = 2'd1,
      ST_XFER  = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST_PTR = AW'(FRM_WORDS - 1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   // synchroniser chains, bit 1 is the synced value
   logic [1:0]    r_cs_s;
   logic [1:0]    r_oe_s;
   logic [1:0]    r_we_s;
   logic          r_rd_act_d;
   logic          r_wr_act_d;
   logic [1:0]    r_addr;
   logic [DW-1:0] r_data_q;

   state_t        r_state;
   logic [AW-1:0] r_ptr;
   logic          r_frm;
   logic          r_rd;
   logic [DW-1:0] r_arm_data;
   logic [7:0]    r_err_cnt;

   state_t        w_state_nxt;
   logic [AW-1:0] w_ptr_nxt;
   logic          w_frm_nxt;
   logic          w_rd_nxt;
   logic [DW-1:0] w_arm_data_nxt;
   logic [7:0]    w_err_nxt;

   logic          w_rd_act;
   logic          w_wr_act;
   logic          w_rd_start;
   logic          w_rd_end;
   logic          w_wr_start;
   logic          w_wr_end;
   logic          w_data_start;
   logic          w_abort;
   logic          w_busy;
   logic [DW-1:0] w_status;

   assign w_rd_act     = ~r_cs_s[1] & ~r_oe_s[1];
   assign w_wr_act     = ~r_cs_s[1] & ~r_we_s[1];
   assign w_rd_start   = w_rd_act & ~r_rd_act_d;
   assign w_rd_end     = ~w_rd_act & r_rd_act_d;
   assign w_wr_start   = w_wr_act & ~r_wr_act_d;
   assign w_wr_end     = ~w_wr_act & r_wr_act_d;
   assign w_data_start = w_rd_start & (arm_addr == 2'd1);
   assign w_abort      = w_wr_end & (r_addr == 2'd2);
   assign w_busy       = w_rd_act | w_wr_act | r_rd_act_d | r_wr_act_d;

   // the pad enable follows the raw pins so the ARM sees the bus driven immediately
   assign arm_data_oe = ~arm_cs_n & ~arm_oe_n;
   assign arm_data    = r_arm_data;
   assign buf_raddr   = r_ptr;
   assign buf_frm     = r_frm;
   assign buf_rd      = r_rd;
   assign err_cnt     = r_err_cnt;

   // synchronisers and edge-detect stage; left out of reset so a strobe held
   // across reset does not look like a fresh access afterwards
   always_ff @(posedge clk_sys) begin
      r_cs_s     <= {r_cs_s[0], arm_cs_n};
      r_oe_s     <= {r_oe_s[0], arm_oe_n};
      r_we_s     <= {r_we_s[0], arm_we_n};
      r_rd_act_d <= w_rd_act;
      r_wr_act_d <= w_wr_act;
   end

   // address capture on access start and prefetch of word[ptr] while the bus is idle
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         r_addr   <= 2'd0;
         r_data_q <= '0;
      end else begin
         if (w_rd_start | w_wr_start) begin
            r_addr <= arm_addr;
         end
         if (!w_busy) begin
            r_data_q <= buf_rdata;
         end
      end
   end

   // status word: state in the top two bits, pointer right-aligned, zeros between
   always_comb begin
      w_status                = '0;
      w_status[AW-1:0]        = r_ptr;
      w_status[DW-1:DW-2]     = r_state;
   end

   // FSM state and output registers
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_frm      <= 1'b0;
         r_rd       <= 1'b0;
         r_arm_data <= '0;
         r_err_cnt  <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_frm      <= w_frm_nxt;
         r_rd       <= w_rd_nxt;
         r_arm_data <= w_arm_data_nxt;
         r_err_cnt  <= w_err_nxt;
      end
   end

   // next-state, read latch, pointer and error counter logic
   always_comb begin
      w_state_nxt    = r_state;
      w_ptr_nxt      = r_ptr;
      w_frm_nxt      = r_frm;
      w_rd_nxt       = r_rd;
      w_arm_data_nxt = r_arm_data;
      w_err_nxt      = r_err_cnt;

      if (w_rd_start) begin
         case (arm_addr)
            2'd0:    w_arm_data_nxt = w_status;
            2'd1:    w_arm_data_nxt = r_data_q;
            default: w_arm_data_nxt = '0;
         endcase
      end

      case (r_state)
         ST_IDLE: begin
            w_ptr_nxt = '0;
            if (w_data_start) begin
               // no frame is ready: return 0 and count the illegal read
               w_arm_data_nxt = '0;
               if (r_err_cnt != 8'hFF) begin
                  w_err_nxt = r_err_cnt + 8'd1;
               end
            end else if (stu_buf_rdy != 8'd0) begin
               w_state_nxt = ST_READY;
            end
         end
         ST_READY: begin
            // first data read opens the frame and itself returns word 0
            if (w_data_start) begin
               w_frm_nxt   = 1'b1;
               w_rd_nxt    = 1'b1;
               w_state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            if (w_data_start) begin
               w_rd_nxt = 1'b1;
            end
            if (w_rd_end && r_rd) begin
               w_rd_nxt = 1'b0;
               if (r_ptr == LAST_PTR) begin
                  w_ptr_nxt   = '0;
                  w_frm_nxt   = 1'b0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_ptr_nxt = r_ptr + PTR_ONE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = '0;
            w_frm_nxt   = 1'b0;
            w_rd_nxt    = 1'b0;
         end
      endcase

      // abort write closes any frame from any state
      if (w_abort) begin
         w_ptr_nxt   = '0;
         w_frm_nxt   = 1'b0;
         w_rd_nxt    = 1'b0;
         w_state_nxt = ST_IDLE;
      end
   end

endmodule

// File: tb/tb_commu_m_arm_rd.sv
// tb/tb_commu_m_arm_rd.sv - directed self-checking bench for commu_m_arm_rd
module tb_commu_m_arm_rd;

   localparam int AW = 10;
   localparam int DW = 16;
   localparam int FW = 8;

   logic          clk_sys;
   logic          rst;
   logic          arm_cs_n;
   logic          arm_oe_n;
   logic          arm_we_n;
   logic [1:0]    arm_addr;
   logic [DW-1:0] arm_data;
   logic          arm_data_oe;
   logic [7:0]    stu_buf_rdy;
   logic [AW-1:0] buf_raddr;
   logic [DW-1:0] buf_rdata;
   logic          buf_frm;
   logic          buf_rd;
   logic [7:0]    err_cnt;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int tests;
   int fails;
   int rd_pulses;
   int frm_hi;
   logic rd_q;
   logic last_frm;
   logic last_rd;
   logic last_oe;

   commu_m_arm_rd #(.AW(AW), .DW(DW), .FRM_WORDS(FW)) dut (
      .clk_sys     (clk_sys),
      .rst         (rst),
      .arm_cs_n    (arm_cs_n),
      .arm_oe_n    (arm_oe_n),
      .arm_we_n    (arm_we_n),
      .arm_addr    (arm_addr),
      .arm_data    (arm_data),
      .arm_data_oe (arm_data_oe),
      .stu_buf_rdy (stu_buf_rdy),
      .buf_raddr   (buf_raddr),
      .buf_rdata   (buf_rdata),
      .buf_frm     (buf_frm),
      .buf_rd      (buf_rd),
      .err_cnt     (err_cnt)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // frame-buffer RAM model with one cycle read latency
   always @(posedge clk_sys) buf_rdata <= mem[buf_raddr];

   // buf_rd pulse and buf_frm high-cycle monitors
   initial begin
      rd_pulses = 0;
      frm_hi = 0;
   end
   always @(posedge clk_sys) begin
      if (buf_rd && !rd_q) rd_pulses++;
      if (buf_frm) frm_hi++;
      rd_q <= buf_rd;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // one ARM read: strobe low 4 cycles, data sampled just before release, high 4 cycles
   task automatic arm_read(input logic [1:0] a, output logic [DW-1:0] d);
      arm_addr = a;
      arm_cs_n = 1'b0;
      arm_oe_n = 1'b0;
      #1;
      last_oe = arm_data_oe;
      #38;
      d = arm_data;
      last_frm = buf_frm;
      last_rd = buf_rd;
      #1;
      arm_cs_n = 1'b1;
      arm_oe_n = 1'b1;
      #40;
   endtask

   task automatic arm_write(input logic [1:0] a);
      arm_addr = a;
      arm_cs_n = 1'b0;
      arm_we_n = 1'b0;
      #40;
      arm_cs_n = 1'b1;
      arm_we_n = 1'b1;
      #40;
   endtask

   task automatic align(input int sk);
      @(posedge clk_sys);
      #(sk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      arm_cs_n = 1'b1;
      arm_oe_n = 1'b1;
      arm_we_n = 1'b1;
      arm_addr = 2'd0;
      stu_buf_rdy = 8'd0;
      repeat (5) @(posedge clk_sys);
      #1;
      tests++; if (buf_frm !== 1'b0) begin fails++; $display("FAIL reset_frm got %b exp 0", buf_frm); end
      tests++; if (buf_rd !== 1'b0) begin fails++; $display("FAIL reset_rd got %b exp 0", buf_rd); end
      tests++; if (arm_data !== 16'h0000) begin fails++; $display("FAIL reset_data got %h exp 0000", arm_data); end
      tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err got %0d exp 0", err_cnt); end
      tests++; if (buf_raddr !== 10'd0) begin fails++; $display("FAIL reset_raddr got %0d exp 0", buf_raddr); end
      tests++; if (arm_data_oe !== 1'b0) begin fails++; $display("FAIL reset_oe got %b exp 0", arm_data_oe); end
      rst = 1'b0;
      repeat (3) @(posedge clk_sys);
   endtask

   task automatic test_full_frame;
      logic [DW-1:0] d;
      int p0;
      align(3);
      p0 = rd_pulses;
      stu_buf_rdy = 8'hFF;
      for (int i = 0; i < FW; i++) begin
         arm_read(2'd1, d);
         tests++; if (d !== 16'hA500 + 16'(i)) begin fails++; $display("FAIL frame_word%0d got %h exp %h", i, d, 16'hA500 + 16'(i)); end
         tests++; if (last_frm !== 1'b1 || last_rd !== 1'b1) begin fails++; $display("FAIL frame_flags%0d got frm=%b rd=%b exp 1 1", i, last_frm, last_rd); end
         if (i == 0) begin
            tests++; if (last_oe !== 1'b1) begin fails++; $display("FAIL frame_oe got %b exp 1", last_oe); end
            stu_buf_rdy = 8'd0;
         end
      end
      tests++; if (buf_frm !== 1'b0 || buf_rd !== 1'b0) begin fails++; $display("FAIL frame_end got frm=%b rd=%b exp 0 0", buf_frm, buf_rd); end
      tests++; if (rd_pulses - p0 !== 8) begin fails++; $display("FAIL frame_pulses got %0d exp 8", rd_pulses - p0); end
      tests++; if (buf_raddr !== 10'd0) begin fails++; $display("FAIL frame_ptr got %0d exp 0", buf_raddr); end
      arm_read(2'd0, d);
      tests++; if (d !== 16'h0000) begin fails++; $display("FAIL frame_status got %h exp 0000", d); end
      tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL frame_err got %0d exp 0", err_cnt); end
   endtask

   task automatic test_status;
      logic [DW-1:0] d;
      align(7);
      stu_buf_rdy = 8'hFF;
      arm_read(2'd0, d);
      tests++; if (d !== 16'h4000) begin fails++; $display("FAIL status_ready got %h exp 4000", d); end
      for (int i = 0; i < 3; i++) begin
         arm_read(2'd1, d);
         stu_buf_rdy = 8'd0;
         tests++; if (d !== 16'hA500 + 16'(i)) begin fails++; $display("FAIL status_pre%0d got %h exp %h", i, d, 16'hA500 + 16'(i)); end
      end
      arm_read(2'd0, d);
      tests++; if (d !== 16'h8003) begin fails++; $display("FAIL status_xfer got %h exp 8003", d); end
      for (int i = 3; i < FW; i++) begin
         arm_read(2'd1, d);
         tests++; if (d !== 16'hA500 + 16'(i)) begin fails++; $display("FAIL status_post%0d got %h exp %h", i, d, 16'hA500 + 16'(i)); end
      end
      arm_read(2'd3, d);
      tests++; if (d !== 16'h0000) begin fails++; $display("FAIL status_addr3 got %h exp 0000", d); end
   endtask

   task automatic test_illegal;
      logic [DW-1:0] d;
      int p0;
      int f0;
      int bad;
      align(5);
      stu_buf_rdy = 8'd0;
      p0 = rd_pulses;
      f0 = frm_hi;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         arm_read(2'd1, d);
         if (d !== 16'h0000) bad++;
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL illegal_data got %0d nonzero reads exp 0", bad); end
      tests++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL illegal_err got %0d exp 255", err_cnt); end
      tests++; if (rd_pulses - p0 !== 0) begin fails++; $display("FAIL illegal_rd got %0d pulses exp 0", rd_pulses - p0); end
      tests++; if (frm_hi - f0 !== 0) begin fails++; $display("FAIL illegal_frm got %0d cycles exp 0", frm_hi - f0); end
   endtask

   task automatic test_abort;
      logic [DW-1:0] d;
      align(2);
      stu_buf_rdy = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         arm_read(2'd1, d);
         stu_buf_rdy = 8'd0;
      end
      tests++; if (d !== 16'hA504 || buf_frm !== 1'b1) begin fails++; $display("FAIL abort_pre got %h frm=%b exp a504 1", d, buf_frm); end
      arm_write(2'd1);
      tests++; if (buf_frm !== 1'b1 || buf_raddr !== 10'd5) begin fails++; $display("FAIL abort_wr1 got frm=%b ptr=%0d exp 1 5", buf_frm, buf_raddr); end
      arm_write(2'd2);
      tests++; if (buf_frm !== 1'b0 || buf_rd !== 1'b0) begin fails++; $display("FAIL abort_flags got frm=%b rd=%b exp 0 0", buf_frm, buf_rd); end
      arm_read(2'd0, d);
      tests++; if (d !== 16'h0000) begin fails++; $display("FAIL abort_status got %h exp 0000", d); end
      stu_buf_rdy = 8'hFF;
      for (int i = 0; i < FW; i++) begin
         arm_read(2'd1, d);
         stu_buf_rdy = 8'd0;
         tests++; if (d !== 16'hA500 + 16'(i)) begin fails++; $display("FAIL abort_next%0d got %h exp %h", i, d, 16'hA500 + 16'(i)); end
      end
      tests++; if (buf_frm !== 1'b0) begin fails++; $display("FAIL abort_end got frm=%b exp 0", buf_frm); end
   endtask

   task automatic test_reset_mid;
      logic [DW-1:0] d;
      align(4);
      stu_buf_rdy = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         arm_read(2'd1, d);
         stu_buf_rdy = 8'd0;
      end
      tests++; if (buf_frm !== 1'b1 || arm_data !== 16'hA504) begin fails++; $display("FAIL mid_pre got frm=%b data=%h exp 1 a504", buf_frm, arm_data); end
      @(posedge clk_sys);
      #1;
      rst = 1'b1;
      @(posedge clk_sys);
      #1;
      tests++; if (buf_frm !== 1'b0 || buf_rd !== 1'b0) begin fails++; $display("FAIL mid_flags got frm=%b rd=%b exp 0 0", buf_frm, buf_rd); end
      tests++; if (arm_data !== 16'h0000) begin fails++; $display("FAIL mid_data got %h exp 0000", arm_data); end
      tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL mid_err got %0d exp 0", err_cnt); end
      tests++; if (buf_raddr !== 10'd0) begin fails++; $display("FAIL mid_ptr got %0d exp 0", buf_raddr); end
      rst = 1'b0;
      repeat (3) @(posedge clk_sys);
      #2;
      arm_read(2'd0, d);
      tests++; if (d !== 16'h0000) begin fails++; $display("FAIL mid_status got %h exp 0000", d); end
   endtask

   task automatic test_min_timing;
      logic [DW-1:0] d;
      int mism;
      int sk;
      mism = 0;
      for (int f = 0; f < 64; f++) begin
         sk = int'($urandom_range(9, 1));
         align(sk);
         stu_buf_rdy = 8'hFF;
         for (int i = 0; i < FW; i++) begin
            arm_read(2'd1, d);
            stu_buf_rdy = 8'd0;
            if (d !== 16'hA500 + 16'(i)) mism++;
         end
         if (buf_frm !== 1'b0) mism++;
      end
      tests++; if (mism !== 0) begin fails++; $display("FAIL min_timing got %0d mismatches exp 0", mism); end
      tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL min_timing_err got %0d exp 0", err_cnt); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hA500 + 16'(i);
      test_reset();
      test_full_frame();
      test_status();
      test_illegal();
      test_abort();
      test_reset_mid();
      test_min_timing();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/commu_m_arm_rd.md
Name: commu_m_arm_rd

Overview:
- ARM-facing read engine for the master-side frame buffer; the reader end of the ARM interrupt/buffer handshake.
- Interrupt logic raises the buffer-ready status; this block serves asynchronous ARM external-bus reads of the buffered frame.
- It generates the buf_frm (frame read in progress) and buf_rd (word read in progress) indications consumed by the interrupt logic.
- Sits between the ARM EBI pins, the frame-buffer RAM read port and the interrupt/status logic.

Parameters:
- AW, 10, frame-buffer address width.
- DW, 16, data width of the buffer and the ARM bus.
- FRM_WORDS, 512, words per frame; must be at least 2 and no more than 2^AW.

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- arm_cs_n  in  1  ARM chip select; asynchronous, active low.
- arm_oe_n  in  1  ARM output enable (read strobe); asynchronous, active low.
- arm_we_n  in  1  ARM write strobe; asynchronous, active low.
- arm_addr  in  2  ARM register address: 0 = status, 1 = data port, 2 = abort (write only).
- arm_data  out  DW  read data to the ARM pad.
- arm_data_oe  out  1  pad drive enable.
- stu_buf_rdy  in  8  buffer-ready status from the interrupt logic; nonzero means a frame is ready.
- buf_raddr  out  AW  frame-buffer RAM read address.
- buf_rdata  in  DW  frame-buffer RAM read data; 1-cycle latency from buf_raddr.
- buf_frm  out  1  high while an ARM frame read is in progress.
- buf_rd  out  1  high while a data-port read access is active.
- err_cnt  out  8  count of illegal data-port reads; saturates at 255.

Behaviour:
- Synchronisation: cs_n, oe_n and we_n each pass through a 2-FF synchroniser.
  - rd_act = synced ~cs_n & ~oe_n.
  - wr_act = synced ~cs_n & ~we_n.
  - Access start and end are the rising and falling edges of rd_act or wr_act, detected against a third register stage.
  - arm_addr is sampled on the start edge.
- Bus timing requirement: the ARM holds a strobe low for at least 4 clk_sys cycles and high for at least 4 cycles between accesses. Shorter accesses have undefined results.
- arm_data_oe = ~arm_cs_n & ~arm_oe_n from the raw pins. This is the only combinational pin path.
- Reset values: state IDLE, ptr 0, buf_raddr 0, buf_frm 0, buf_rd 0, arm_data 0, err_cnt 0.
- Prefetch:
  - buf_raddr = ptr at all times.
  - data_q <= buf_rdata every cycle while no access is active, so data_q holds word[ptr] two cycles after ptr changes.
- Read latch: on a read start edge, arm_data is loaded and then held until the next start edge.
  - addr 0 loads the status word: {state[1:0], zero pad, ptr} right-aligned in DW.
  - addr 1 loads data_q.
  - Any other address loads 0.
- States (2 bits): IDLE=0, READY=1, XFER=2.
  - IDLE: ptr = 0. When stu_buf_rdy != 0, go to READY.
  - READY: on a read start edge at addr 1, set buf_frm = 1 and go to XFER. That same access returns word 0.
  - XFER:
    - buf_rd = 1 from a data-port read start edge to its end edge.
    - On the end edge, ptr increments.
    - If ptr was FRM_WORDS-1: ptr = 0, buf_frm = 0, go to IDLE. buf_rd and buf_frm fall in the same cycle.
    - stu_buf_rdy is ignored in XFER; it drops once the interrupt logic sees buf_frm rise.
- Abort: a write end edge at addr 2 in any state sets ptr = 0, buf_frm = 0, buf_rd = 0 and returns to IDLE. Write data is ignored. Writes at other addresses are ignored.
- Errors: a data-port read start edge while in IDLE returns 0, makes no state change, and increments err_cnt. err_cnt holds at 255.
- Simultaneity: the abort end edge and a read start edge cannot coincide because the bus is single master. stu_buf_rdy rising in the same cycle as rst is ignored.
- Reset mid-frame: buf_frm falls immediately. Downstream treats this fall as a frame completion; this is accepted behaviour.

Test Plan:
- Full frame, FRM_WORDS=8, RAM preloaded with word[i] = 0xA500 + i, stu_buf_rdy = 0xFF:
  - 8 data reads return 0xA500..0xA507.
  - buf_frm rises at read 0 start and falls with the end of read 7.
  - 8 buf_rd pulses; state returns to IDLE with ptr = 0.
- Status read: after 3 data reads, an addr 0 read returns state = 2 and ptr = 3. A data read then returns 0xA503.
- Illegal read: with stu_buf_rdy = 0, 300 data reads all return 0. err_cnt ends at 255. buf_frm and buf_rd stay 0.
- Abort: after 5 data reads, write to addr 2 gives buf_frm = 0 and IDLE. Re-assert stu_buf_rdy; the next frame starts at 0xA500.
- Reset mid-frame: assert rst after read 4. All outputs and state return to reset values the next cycle, and err_cnt = 0.
- Minimum timing: strobes of exactly 4 cycles low and 4 high with randomized pin-to-clock skew. Zero data mismatches over 64 frames.
